dm_access_ctrl: RTL

//  Load/store unit between the datapath (ALU address, rt store data) and DM.
//  DM is word-addressed with whole-word writes only; this block converts byte

---
 rtl/dm_access_ctrl_if.sv | 29 ++
 rtl/dm_access_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl_if.sv
// rtl/dm_access_ctrl_if.sv - datapath request and DM port bundle for dm_access_ctrl
interface dm_access_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              stall;
    logic              done;
    logic              addr_err;
    logic [ADDR_W-3:0] dm_addr;
    logic [31:0]       dm_din;
    logic              dm_wr;
    logic [31:0]       dm_dout;

    modport slave (
        input  req, we, size, uns, addr, wdata, dm_dout,
        output rdata, stall, done, addr_err, dm_addr, dm_din, dm_wr
    );

    modport master (
        output req, we, size, uns, addr, wdata, dm_dout,
        input  rdata, stall, done, addr_err, dm_addr, dm_din, dm_wr
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - load/store unit for word-only DM with sub-word RMW; optional trap via DM_MISALIGN_TRAP_EN
module dm_access_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    dm_access_ctrl_if.slave   bus
);
    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-3:0] lat_addr;
    logic [31:0]       merged;
    logic [31:0]       merge_val;
    logic [31:0]       load_val;
    logic [31:0]       lane_shift;
    logic [15:0]       lane_half;
    logic [ADDR_W-3:0] word_addr;
    logic              is_word;
    logic              is_half;
    logic              misalign;
    logic              start_rmw;

    // size 11 decodes as word because only the top bit is inspected
    assign word_addr = bus.addr[ADDR_W-1:2];
    assign is_word   = bus.size[1];
    assign is_half   = (bus.size == 2'b01);

`ifdef DM_MISALIGN_TRAP_EN
    assign misalign = (is_half && bus.addr[0]) || (is_word && (bus.addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign start_rmw = (state == IDLE) && bus.req && bus.we && !is_word && !misalign;

    // select the addressed lane from the DM word and extend it
    always_comb begin
        lane_shift = bus.dm_dout >> {bus.addr[1:0], 3'b000};
        lane_half  = bus.addr[1] ? bus.dm_dout[31:16] : bus.dm_dout[15:0];
        load_val   = bus.dm_dout;
        if (bus.size == 2'b00) begin
            load_val = bus.uns ? {24'h0, lane_shift[7:0]}
                               : {{24{lane_shift[7]}}, lane_shift[7:0]};
        end else if (is_half) begin
            load_val = bus.uns ? {16'h0, lane_half}
                               : {{16{lane_half[15]}}, lane_half};
        end
    end

    // overlay the store data onto the current DM word for the write-back cycle
    always_comb begin
        merge_val = bus.dm_dout;
        if (is_half) begin
            if (bus.addr[1]) begin
                merge_val[31:16] = bus.wdata[15:0];
            end else begin
                merge_val[15:0] = bus.wdata[15:0];
            end
        end else begin
            merge_val[{bus.addr[1:0], 3'b000} +: 8] = bus.wdata[7:0];
        end
    end

    // state register plus captured write-back address and data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat_addr <= '0;
            merged   <= '0;
        end else begin
            state <= state_nx;
            if (start_rmw) begin
                lat_addr <= word_addr;
                merged   <= merge_val;
            end
        end
    end

    // next state and DM/datapath outputs; reset forces every strobe quiet
    always_comb begin
        state_nx     = state;
        bus.dm_addr  = word_addr;
        bus.dm_din   = bus.wdata;
        bus.dm_wr    = 1'b0;
        bus.stall    = 1'b0;
        bus.done     = 1'b0;
        bus.addr_err = 1'b0;
        bus.rdata    = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        if (misalign) begin
                            bus.addr_err = 1'b1;
                            bus.done     = 1'b1;
                        end else if (!bus.we) begin
                            bus.rdata = load_val;
                            bus.done  = 1'b1;
                        end else if (is_word) begin
                            bus.dm_wr = 1'b1;
                            bus.done  = 1'b1;
                        end else begin
                            bus.stall = 1'b1;
                            state_nx  = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    bus.dm_addr = lat_addr;
                    bus.dm_din  = merged;
                    bus.dm_wr   = 1'b1;
                    bus.done    = 1'b1;
                    state_nx    = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end
endmodule
